uart_frame_ctrl: RTL and testbench
==================================

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 25000, inter-byte timeout in CLK cycles.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  sole clock, all logic on posedge; RESET_N  in  1  asynchronous active-low reset.
REQ-005 SHALL have RX_DATA  in  8  received byte from UART receiver.
REQ-006 SHALL have RX_NEW  in  1  byte-available strobe from UART receiver (level, may last more than one cycle).
REQ-007 SHALL have PL_DATA  out  8  payload byte; PL_VALID  out  1  payload byte valid; PL_READY  in  1  sink accepts byte; PL_LAST  out  1  current byte is the final payload byte.
REQ-008 SHALL have FRAME_OK  out  1  one-cycle pulse, frame accepted; FRAME_ERR  out  1  one-cycle pulse, error; ERR_CODE  out  2  error cause, held until next error; BUSY  out  1  high when state is not IDLE.

Function
REQ-009 SHALL accept a byte only on an RX_NEW rising edge (RX_NEW high, registered previous RX_NEW low); one byte per edge.
REQ-010 SHALL implement states IDLE, LEN, PAYLOAD, CSUM, DRAIN.
REQ-011 IDLE: accepted byte == SYNC_BYTE -> LEN; any other byte is dropped silently and the state stays IDLE.
REQ-012 LEN: byte stored as len and seeds the running sum; len == 0 -> CSUM; 1..MAX_LEN -> PAYLOAD; len > MAX_LEN -> FRAME_ERR, ERR_CODE=1, IDLE.
REQ-013 PAYLOAD: each byte is written to buffer[idx], idx increments, and sum = (sum + byte) mod 256; after the len-th byte -> CSUM.
REQ-014 CSUM: byte == sum -> FRAME_OK the next cycle, then DRAIN if len>0, else IDLE; mismatch -> FRAME_ERR, ERR_CODE=0, IDLE, with the buffer discarded.
REQ-015 Timeout counter SHALL clear on every accepted byte and on state entry; reaching TIMEOUT in LEN/PAYLOAD/CSUM -> FRAME_ERR, ERR_CODE=2, IDLE.
REQ-016 DRAIN: PL_VALID=1 and PL_DATA=buffer[rd]; a transfer occurs on PL_VALID & PL_READY and rd increments; PL_LAST=1 when rd==len-1; the cycle after the last transfer -> IDLE.
REQ-017 PL_VALID SHALL first assert in the same cycle as FRAME_OK, i.e. one cycle after the checksum byte edge.
REQ-018 PL_DATA and PL_LAST SHALL remain stable while PL_VALID & !PL_READY.
REQ-019 A byte accepted in DRAIN SHALL be dropped and SHALL raise FRAME_ERR with ERR_CODE=3 (overrun); draining continues unaffected.
REQ-020 No timeout SHALL apply in IDLE or DRAIN.
REQ-021 Buffer depth SHALL equal MAX_LEN; idx/rd width SHALL be clog2(MAX_LEN+1); the sum SHALL wrap modulo 256.
REQ-022 FRAME_OK and FRAME_ERR SHALL never assert in the same cycle.

Reset
REQ-023 RESET_N low SHALL asynchronously force IDLE with len, idx, rd, sum and the timeout counter at 0 and registered RX_NEW at 0.
REQ-024 Reset values SHALL be: PL_DATA=0, PL_VALID=0, PL_LAST=0, FRAME_OK=0, FRAME_ERR=0, ERR_CODE=0, BUSY=0.
REQ-025 Reset mid-frame or mid-drain SHALL discard the partial frame; no pulse is generated on reset release.

Configuration
REQ-026 Macro UART_FRAME_CSUM_EN: when defined, the CSUM state and checksum check are present as in REQ-014.
REQ-027 When UART_FRAME_CSUM_EN is undefined, there SHALL be no CSUM byte: after the len-th payload byte, FRAME_OK fires the next cycle and the state goes to DRAIN; len==0 gives FRAME_OK then IDLE; ERR_CODE=0 is never produced.

Verification
REQ-028 Good frame A5,03,11,22,33,69 with PL_READY=1 -> FRAME_OK once; PL_DATA 11,22,33 on consecutive cycles; PL_LAST with 33; BUSY low after.
REQ-029 Bad checksum A5,02,10,20,00 -> FRAME_ERR, ERR_CODE=0, PL_VALID never high.
REQ-030 Length A5,11 (17 > MAX_LEN) -> FRAME_ERR, ERR_CODE=1; a following A5,00,00 -> FRAME_OK, no PL_VALID.
REQ-031 A5,02,AA then silence for 25000 cycles -> FRAME_ERR, ERR_CODE=2, IDLE; leading junk 00,FF before A5 is ignored.
REQ-032 Good frame with PL_READY=0 for 10 cycles then 1, plus a byte 55 sent during DRAIN -> PL_DATA held stable; FRAME_ERR with ERR_CODE=3; all payload delivered intact.
REQ-033 RESET_N pulsed low during PAYLOAD -> all outputs 0 immediately; next good frame received correctly.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: turns a stream of UART bytes into checked payload frames.
// Frame layout: SYNC_BYTE, LEN, LEN payload bytes, and (optionally) a checksum byte
// equal to (LEN + sum of payload) mod 256. Accepted payload is replayed on a
// valid/ready stream (PL_*) once the whole frame has been accepted.
// Optional feature macro: UART_FRAME_CSUM_EN (checksum byte and CSUM state present).
// Without it, a frame is accepted as soon as its last payload byte arrives.
// Error codes: 0 checksum mismatch, 1 length too large, 2 inter-byte timeout,
// 3 byte received while the payload is still being drained (byte dropped).
module uart_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 25000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] RX_DATA,
  input  logic       RX_NEW,
  output logic [7:0] PL_DATA,
  output logic       PL_VALID,
  input  logic       PL_READY,
  output logic       PL_LAST,
  output logic       FRAME_OK,
  output logic       FRAME_ERR,
  output logic [1:0] ERR_CODE,
  output logic       BUSY
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
`ifdef UART_FRAME_CSUM_EN
    ST_CSUM    = 3'd3,
`endif
    ST_DRAIN   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic             rx_new_q;
  logic [7:0]       len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             buf_we;

  logic [7:0] buffer [MAX_LEN];

  logic              accept;
  logic              timed;
  logic              timeout_hit;
  logic [7:0]        idx_ext;
  logic [7:0]        rd_ext;
  logic              rd_is_last;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // A byte is taken only on the rising edge of the receiver's level strobe.
  assign accept = RX_NEW & ~rx_new_q;

`ifdef UART_FRAME_CSUM_EN
  assign timed = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
`else
  assign timed = (state_q == ST_LEN) || (state_q == ST_PAYLOAD);
`endif

  assign timeout_hit = timed && (tmr_q == TMR_LAST);
  assign idx_ext     = 8'(idx_q);
  assign rd_ext      = 8'(rd_q);
  assign rd_is_last  = (rd_ext == (len_q - 8'd1));
  assign wr_addr     = ADDR_W'(idx_q);
  assign rd_addr     = ADDR_W'(rd_q);

  // Next-state and next-value logic for the frame parser and the drain side.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    sum_d       = sum_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && (RX_DATA == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (accept) begin
          len_d = RX_DATA;
          sum_d = RX_DATA;
          idx_d = '0;
          if (RX_DATA == 8'd0) begin
`ifdef UART_FRAME_CSUM_EN
            state_d = ST_CSUM;
`else
            frame_ok_d = 1'b1;
            state_d    = ST_IDLE;
`endif
          end else if (RX_DATA > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          buf_we = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
          sum_d  = sum_q + RX_DATA;
          if (idx_ext == (len_q - 8'd1)) begin
`ifdef UART_FRAME_CSUM_EN
            state_d = ST_CSUM;
`else
            frame_ok_d = 1'b1;
            rd_d       = '0;
            state_d    = ST_DRAIN;
`endif
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = ST_IDLE;
        end
      end

`ifdef UART_FRAME_CSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (RX_DATA == sum_q) begin
            frame_ok_d = 1'b1;
            if (len_q != 8'd0) begin
              rd_d    = '0;
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd0;
            state_d     = ST_IDLE;
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = ST_IDLE;
        end
      end
`endif

      ST_DRAIN: begin
        if (accept) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
        end
        if (PL_READY) begin
          if (rd_is_last) begin
            state_d = ST_IDLE;
          end else begin
            rd_d = rd_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept || (state_d != state_q) || !timed) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  // State, counters, pulse and error-code registers, all cleared by reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      rx_new_q    <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      sum_q       <= '0;
      tmr_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      rx_new_q    <= RX_NEW;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      sum_q       <= sum_d;
      tmr_q       <= tmr_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload storage; contents are meaningless outside DRAIN so no reset is needed.
  always_ff @(posedge CLK) begin
    if (buf_we) begin
      buffer[wr_addr] <= RX_DATA;
    end
  end

  assign PL_VALID  = (state_q == ST_DRAIN);
  assign PL_DATA   = PL_VALID ? buffer[rd_addr] : 8'h00;
  assign PL_LAST   = PL_VALID & rd_is_last;
  assign FRAME_OK  = frame_ok_q;
  assign FRAME_ERR = frame_err_q;
  assign ERR_CODE  = err_code_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Testbench for uart_frame_ctrl: directed scenarios plus randomized frames, with
// expectations derived from the frame kind (good / bad checksum / too long / timeout).
// Follows the UART_FRAME_CSUM_EN macro the same way the design does.
module tb_uart_frame_ctrl;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXL = 16;
  localparam int TO   = 25000;

  localparam int K_GOOD    = 0;
  localparam int K_BADSUM  = 1;
  localparam int K_LONG    = 2;
  localparam int K_TIMEOUT = 3;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_NEW = 1'b0;
  logic [7:0] PL_DATA;
  logic       PL_VALID;
  logic       PL_READY = 1'b1;
  logic       PL_LAST;
  logic       FRAME_OK;
  logic       FRAME_ERR;
  logic [1:0] ERR_CODE;
  logic       BUSY;

  uart_frame_ctrl #(
    .SYNC_BYTE(SYNC),
    .MAX_LEN(MAXL),
    .TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .RX_DATA(RX_DATA),
    .RX_NEW(RX_NEW),
    .PL_DATA(PL_DATA),
    .PL_VALID(PL_VALID),
    .PL_READY(PL_READY),
    .PL_LAST(PL_LAST),
    .FRAME_OK(FRAME_OK),
    .FRAME_ERR(FRAME_ERR),
    .ERR_CODE(ERR_CODE),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int         okCnt = 0;
  int         okCyc = -1;
  int         firstValidCyc = -1;
  int         errCyc = -1;
  int         errCodes[$];
  logic [7:0] gotData[$];
  bit         gotLast[$];
  int         xferCyc[$];
  bit         prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  bit         prevLast = 1'b0;

  int         readyMode = 1;
  int         lastEdgeCyc = 0;
  logic [7:0] payQ[$];
  logic [7:0] junkQ[$];
  logic [7:0] badMask = 8'h01;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clearMonitor();
    okCnt = 0;
    okCyc = -1;
    firstValidCyc = -1;
    errCyc = -1;
    errCodes.delete();
    gotData.delete();
    gotLast.delete();
    xferCyc.delete();
  endtask

  // Sink side: 0 = stalled, 1 = always ready, 2 = random back-pressure.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (readyMode == 0) PL_READY = 1'b0;
      else if (readyMode == 1) PL_READY = 1'b1;
      else PL_READY = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: collects pulses and transfers, and checks hold-while-stalled behaviour.
  always @(negedge CLK) begin
    if (FRAME_OK || FRAME_ERR) checkOutput("ok_err_exclusive", 32'(FRAME_OK & FRAME_ERR), 32'd0);
    if (FRAME_OK) begin
      okCnt++;
      okCyc = cyc;
    end
    if (FRAME_ERR) begin
      errCodes.push_back(int'(ERR_CODE));
      errCyc = cyc;
    end
    if (PL_VALID && firstValidCyc < 0) firstValidCyc = cyc;
    if (prevStall && PL_VALID) begin
      checkOutput("hold_data", 32'(PL_DATA), 32'(prevData));
      checkOutput("hold_last", 32'(PL_LAST), 32'(prevLast));
    end
    if (PL_VALID && PL_READY) begin
      gotData.push_back(PL_DATA);
      gotLast.push_back(PL_LAST);
      xferCyc.push_back(cyc);
    end
    prevStall = PL_VALID && !PL_READY;
    prevData  = PL_DATA;
    prevLast  = PL_LAST;
  end

  task automatic sendByte(input logic [7:0] b);
    @(negedge CLK);
    RX_DATA = b;
    RX_NEW  = 1'b1;
    lastEdgeCyc = cyc;
    repeat ($urandom_range(1, 3)) @(negedge CLK);
    RX_NEW  = 1'b0;
    RX_DATA = 8'($urandom_range(0, 255));
    repeat ($urandom_range(0, 2)) @(negedge CLK);
  endtask

  // Sends one frame described by kind/lenByte (payload in payQ, leading junk in junkQ)
  // and compares everything observed against the outcome that kind must produce.
  task automatic applyStimulus(input int kind, input logic [7:0] lenByte, input bit overrun);
    int         expOk;
    int         expErr[$];
    int         expPay;
    bit         isGood;
    logic [7:0] csum;
    int         bound;
    int         delta;
    int         n;

    @(posedge CLK);
    clearMonitor();

    csum = lenByte;
    foreach (payQ[i]) csum = csum + payQ[i];

`ifdef UART_FRAME_CSUM_EN
    isGood = (kind == K_GOOD);
`else
    isGood = (kind == K_GOOD) || (kind == K_BADSUM);
`endif
    expOk  = isGood ? 1 : 0;
    expPay = isGood ? payQ.size() : 0;
    if (kind == K_BADSUM && !isGood) expErr.push_back(0);
    if (kind == K_LONG) expErr.push_back(1);
    if (kind == K_TIMEOUT) expErr.push_back(2);
    if (overrun) expErr.push_back(3);

    foreach (junkQ[i]) sendByte(junkQ[i]);
    sendByte(SYNC);
    sendByte(lenByte);
    if (kind != K_LONG) begin
      foreach (payQ[i]) sendByte(payQ[i]);
    end
`ifdef UART_FRAME_CSUM_EN
    if (kind == K_GOOD) sendByte(csum);
    if (kind == K_BADSUM) sendByte(csum ^ badMask);
`endif

    if (kind == K_TIMEOUT) begin
      bound = 0;
      while (errCodes.size() == 0 && bound < TO + 50) begin
        @(negedge CLK);
        bound++;
      end
      delta = errCyc - lastEdgeCyc;
      checkOutput("timeout_delay_in_window", 32'(delta >= TO && delta <= TO + 2), 32'd1);
    end

    if (overrun) begin
      sendByte(8'h55);
      repeat (10) @(negedge CLK);
      readyMode = 1;
    end

    bound = 0;
    while (BUSY && bound < 4000) begin
      @(negedge CLK);
      bound++;
    end
    checkOutput("busy_clears", 32'(BUSY), 32'd0);
    repeat (3) @(negedge CLK);

    checkOutput("ok_count", 32'(okCnt), 32'(expOk));
    checkOutput("err_count", 32'(errCodes.size()), 32'(expErr.size()));
    n = (errCodes.size() < expErr.size()) ? errCodes.size() : expErr.size();
    for (int i = 0; i < n; i++) checkOutput("err_code", 32'(errCodes[i]), 32'(expErr[i]));

    checkOutput("payload_count", 32'(gotData.size()), 32'(expPay));
    n = (gotData.size() < expPay) ? gotData.size() : expPay;
    for (int i = 0; i < n; i++) begin
      checkOutput("payload_data", 32'(gotData[i]), 32'(payQ[i]));
      checkOutput("payload_last", 32'(gotLast[i]), 32'(i == expPay - 1));
    end
    if (expPay > 0) checkOutput("valid_with_ok", 32'(firstValidCyc), 32'(okCyc));
    else checkOutput("no_valid", 32'(firstValidCyc), 32'hFFFF_FFFF);
  endtask

  task automatic checkAllZero(input string when);
    checkOutput({when, "_pl_data"}, 32'(PL_DATA), 32'd0);
    checkOutput({when, "_pl_valid"}, 32'(PL_VALID), 32'd0);
    checkOutput({when, "_pl_last"}, 32'(PL_LAST), 32'd0);
    checkOutput({when, "_frame_ok"}, 32'(FRAME_OK), 32'd0);
    checkOutput({when, "_frame_err"}, 32'(FRAME_ERR), 32'd0);
    checkOutput({when, "_err_code"}, 32'(ERR_CODE), 32'd0);
    checkOutput({when, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    int         len;

    $display("[TB] starting uart_frame_ctrl bench");
    readyMode = 1;
    #1;
    checkAllZero("reset");
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Good frame 11,22,33 with an always-ready sink: one byte per cycle.
    junkQ.delete();
    payQ.delete();
    payQ.push_back(8'h11);
    payQ.push_back(8'h22);
    payQ.push_back(8'h33);
    applyStimulus(K_GOOD, 8'd3, 1'b0);
    for (int i = 1; i < xferCyc.size(); i++)
      checkOutput("consecutive_xfer", 32'(xferCyc[i] - xferCyc[i-1]), 32'd1);

    // Bad checksum: A5,02,10,20,00.
    payQ.delete();
    payQ.push_back(8'h10);
    payQ.push_back(8'h20);
    badMask = 8'h32;
    applyStimulus(K_BADSUM, 8'd2, 1'b0);

    // Length 17 is rejected, then an empty frame is accepted.
    payQ.delete();
    applyStimulus(K_LONG, 8'h11, 1'b0);
    applyStimulus(K_GOOD, 8'h00, 1'b0);

    // Maximum length frame under random back-pressure.
    readyMode = 2;
    for (int i = 0; i < MAXL; i++) payQ.push_back(8'($urandom_range(0, 255)));
    applyStimulus(K_GOOD, 8'(MAXL), 1'b0);
    readyMode = 1;

    // Leading junk, then a frame that stalls mid-payload.
    junkQ.push_back(8'h00);
    junkQ.push_back(8'hFF);
    payQ.delete();
    payQ.push_back(8'hAA);
    applyStimulus(K_TIMEOUT, 8'd2, 1'b0);
    junkQ.delete();

    // Stalled sink plus an overrun byte during the drain.
    readyMode = 0;
    payQ.delete();
    payQ.push_back(8'hDE);
    payQ.push_back(8'hAD);
    payQ.push_back(8'hBE);
    payQ.push_back(8'hEF);
    applyStimulus(K_GOOD, 8'd4, 1'b1);
    readyMode = 1;

    // Reset pulsed in the middle of a payload.
    sendByte(SYNC);
    sendByte(8'd5);
    sendByte(8'h01);
    sendByte(8'h02);
    checkOutput("busy_before_reset", 32'(BUSY), 32'd1);
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    checkAllZero("midframe_reset");
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    clearMonitor();
    repeat (5) @(negedge CLK);
    checkOutput("no_ok_after_reset", 32'(okCnt), 32'd0);
    checkOutput("no_err_after_reset", 32'(errCodes.size()), 32'd0);
    payQ.delete();
    for (int i = 1; i <= 5; i++) payQ.push_back(8'(i));
    applyStimulus(K_GOOD, 8'd5, 1'b0);

    // Randomized frames.
    for (int t = 0; t < 30; t++) begin
      readyMode = ($urandom_range(0, 1) == 0) ? 1 : 2;
      junkQ.delete();
      payQ.delete();
      repeat ($urandom_range(0, 2)) begin
        do b = 8'($urandom_range(0, 255)); while (b == SYNC);
        junkQ.push_back(b);
      end
      r = $urandom_range(0, 9);
      if (r <= 7) begin
        len = $urandom_range(0, MAXL);
        for (int i = 0; i < len; i++) payQ.push_back(8'($urandom_range(0, 255)));
        badMask = 8'($urandom_range(1, 255));
        applyStimulus((r <= 5) ? K_GOOD : K_BADSUM, 8'(len), 1'b0);
      end else begin
        applyStimulus(K_LONG, 8'($urandom_range(MAXL + 1, 255)), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
